pipe_stage_reg: RTL and testbench

- Parametrised pipeline stage register that generalises the fixed 2×32-bit IF/ID latch.
- Carries an arbitrary-width payload under a valid/ready handshake, with synchronous flush (bubble insertion) and an optional 2-entry skid buffer for full-throughput stalls.
- Includes saturating stall and flush event counters for pipeline performance debug.
- Instantiated between any two core pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_reg.sv | 212 +++++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// pipe_stage_reg : valid/ready pipeline register with flush, optional skid
//                  buffer and saturating stall/flush performance counters
// Revision       : 1.0
// ============================================================================
module pipe_stage_reg #(
  parameter int unsigned       WIDTH     = 64,
  parameter int unsigned       SKID      = 1,
  parameter logic [WIDTH-1:0]  CLEAR_VAL = '0,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic in_fire;
  logic out_fire;
  logic any_valid;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      // Encoding mirrors {skid_valid, main_valid}; 2'b10 is never entered.
      localparam logic [1:0] EMPTY = 2'b00;
      localparam logic [1:0] ONE   = 2'b01;
      localparam logic [1:0] FULL  = 2'b11;

      logic [1:0]       state_q;
      logic [1:0]       state_d;
      logic [WIDTH-1:0] main_data_q;
      logic [WIDTH-1:0] main_data_d;
      logic [WIDTH-1:0] skid_data_q;
      logic [WIDTH-1:0] skid_data_d;
      logic             ready_int;
      logic             valid_int;
      logic             load_main_in;
      logic             load_main_skid;
      logic             load_skid;

      always_ff @(posedge clk) begin
        if (reset) begin
          state_q <= EMPTY;
        end else begin
          state_q <= state_d;
        end
      end

      always_comb begin
        state_d = state_q;
        if (flush) begin
          state_d = EMPTY;
        end else begin
          case (state_q)
            EMPTY: if (in_fire) state_d = ONE;
            ONE: begin
              if (in_fire && !out_fire) begin
                state_d = FULL;
              end else if (!in_fire && out_fire) begin
                state_d = EMPTY;
              end
            end
            FULL:    if (out_fire) state_d = ONE;
            default: state_d = EMPTY;
          endcase
        end
      end

      // Uses raw in_valid/out_ready: in_ready is already implied by the state.
      always_comb begin
        ready_int      = 1'b0;
        valid_int      = 1'b0;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
          EMPTY: begin
            ready_int    = 1'b1;
            load_main_in = in_valid;
          end
          ONE: begin
            ready_int    = 1'b1;
            valid_int    = 1'b1;
            load_main_in = in_valid & out_ready;
            load_skid    = in_valid & ~out_ready;
          end
          FULL: begin
            valid_int      = 1'b1;
            load_main_skid = out_ready;
          end
          default: begin
            ready_int = 1'b0;
            valid_int = 1'b0;
          end
        endcase
      end

      always_comb begin
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        if (flush) begin
          main_data_d = CLEAR_VAL;
          skid_data_d = CLEAR_VAL;
        end else begin
          if (load_main_in) begin
            main_data_d = in_data;
          end else if (load_main_skid) begin
            main_data_d = skid_data_q;
          end
          if (load_skid) begin
            skid_data_d = in_data;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          main_data_q <= CLEAR_VAL;
          skid_data_q <= CLEAR_VAL;
        end else begin
          main_data_q <= main_data_d;
          skid_data_q <= skid_data_d;
        end
      end

      assign in_ready  = ready_int;
      assign out_valid = valid_int;
      assign out_data  = main_data_q;
      assign any_valid = |state_q;
    end else begin : g_single
      logic             main_valid_q;
      logic             main_valid_d;
      logic [WIDTH-1:0] main_data_q;
      logic [WIDTH-1:0] main_data_d;

      always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        if (flush) begin
          main_valid_d = 1'b0;
          main_data_d  = CLEAR_VAL;
        end else if (in_fire) begin
          main_valid_d = 1'b1;
          main_data_d  = in_data;
        end else if (out_fire) begin
          main_valid_d = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          main_valid_q <= 1'b0;
          main_data_q  <= CLEAR_VAL;
        end else begin
          main_valid_q <= main_valid_d;
          main_data_q  <= main_data_d;
        end
      end

      assign in_ready  = ~main_valid_q | out_ready;
      assign out_valid = main_valid_q;
      assign out_data  = main_data_q;
      assign any_valid = main_valid_q;
    end
  endgenerate

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  // Counters survive flush on purpose so debug can see how often it happens.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if (flush && any_valid && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// tb_pipe_stage_reg : drives three stage configurations (skid, single-entry,
//                     skid with 2-bit counters) against a queue-style model
// Revision          : 1.0
// ============================================================================
module tb_pipe_stage_reg;

  localparam int          N   = 3;
  localparam logic [63:0] CLR = 64'h13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, out_ready;
  logic [63:0] in_data;

  logic        rdy  [N];
  logic        vld  [N];
  logic [63:0] dat  [N];
  logic [15:0] scnt [N];
  logic [15:0] fcnt [N];
  logic [1:0]  scnt2, fcnt2;

  assign scnt[2] = {14'b0, scnt2};
  assign fcnt[2] = {14'b0, fcnt2};

  pipe_stage_reg #(.WIDTH(64), .SKID(1), .CLEAR_VAL(CLR), .CNT_W(16)) u_skid (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_data(in_data), .out_valid(vld[0]), .out_ready(out_ready), .out_data(dat[0]),
    .stall_cnt(scnt[0]), .flush_cnt(fcnt[0]));

  pipe_stage_reg #(.WIDTH(64), .SKID(0), .CLEAR_VAL(CLR), .CNT_W(16)) u_single (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_data(in_data), .out_valid(vld[1]), .out_ready(out_ready), .out_data(dat[1]),
    .stall_cnt(scnt[1]), .flush_cnt(fcnt[1]));

  pipe_stage_reg #(.WIDTH(64), .SKID(1), .CLEAR_VAL(CLR), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_data(in_data), .out_valid(vld[2]), .out_ready(out_ready), .out_data(dat[2]),
    .stall_cnt(scnt2), .flush_cnt(fcnt2));

  // Reference model: each stage is a FIFO of capacity cap[i].
  int          cap  [N] = '{2, 1, 2};
  int          cmax [N] = '{65535, 65535, 3};
  int          m_cnt [N];
  logic [63:0] m_buf [N][2];
  logic [63:0] m_last[N];
  int          m_st  [N];
  int          m_fl  [N];

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [63:0] dq[$];
  logic [63:0] base;

  function automatic bit m_rdy(int i);
    if (cap[i] == 2) return (m_cnt[i] < 2);
    return (m_cnt[i] == 0) || out_ready;
  endfunction

  task automatic chk(input string tag, input int i, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, i, obs, exp);
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < N; i++) begin
      bit inf, outf;
      inf  = in_valid && m_rdy(i);
      outf = (m_cnt[i] > 0) && out_ready;
      if (reset) begin
        m_cnt[i] = 0; m_last[i] = CLR; m_st[i] = 0; m_fl[i] = 0;
      end else begin
        if ((m_cnt[i] > 0) && !out_ready && (m_st[i] < cmax[i])) m_st[i]++;
        if (flush && (m_cnt[i] > 0) && (m_fl[i] < cmax[i])) m_fl[i]++;
        if (flush) begin
          m_cnt[i] = 0; m_last[i] = CLR;
        end else begin
          if (outf) begin m_buf[i][0] = m_buf[i][1]; m_cnt[i]--; end
          if (inf)  begin m_buf[i][m_cnt[i]] = in_data; m_cnt[i]++; end
          if (m_cnt[i] > 0) m_last[i] = m_buf[i][0];
        end
      end
    end
  endtask

  // Check all outputs against the model, then advance one clock.
  task automatic step(input bit do_chk);
    #1;
    if (do_chk) begin
      for (int i = 0; i < N; i++) begin
        chk("in_ready",  i, 64'(rdy[i]), 64'(m_rdy(i)));
        chk("out_valid", i, 64'(vld[i]), 64'(m_cnt[i] > 0));
        chk("out_data",  i, dat[i], m_last[i]);
        chk("stall_cnt", i, 64'(scnt[i]), 64'(m_st[i]));
        chk("flush_cnt", i, 64'(fcnt[i]), 64'(m_fl[i]));
      end
    end
    if (vld[0] === 1'b1 && out_ready) dq.push_back(dat[0]);
    model_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_last[i] = CLR; m_st[i] = 0; m_fl[i] = 0;
      m_buf[i][0] = '0; m_buf[i][1] = '0;
    end

    // Reset held three cycles with valid input: nothing captured
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 64'hdead; out_ready = 1'b1;
    step(0); step(1); step(1);
    reset = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("rst_valid", i, 64'(vld[i]), 64'd0);
      chk("rst_data",  i, dat[i], CLR);
      chk("rst_ready", i, 64'(rdy[i]), 64'd1);
      chk("rst_stall", i, 64'(scnt[i]), 64'd0);
      chk("rst_flush", i, 64'(fcnt[i]), 64'd0);
    end

    // Full-throughput stream with 1-cycle latency
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1; in_data = 64'(k);
      step(1);
      chk("stream_data", 0, dat[0], 64'(k));
      chk("stream_rdy",  0, 64'(rdy[0]), 64'd1);
    end
    in_valid = 1'b0;
    step(1);

    // Backpressure into FULL, then drain in order
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hA;
    step(1);
    in_data = 64'hB;
    step(1);
    chk("full_rdy",  0, 64'(rdy[0]), 64'd0);
    chk("full_data", 0, dat[0], 64'hA);
    base = 64'(scnt[0]);
    in_data = 64'hC;
    repeat (4) step(1);
    chk("stall4", 0, 64'(scnt[0]), base + 64'd4);
    dq.delete();
    out_ready = 1'b1;
    step(1); step(1);
    in_valid = 1'b0;
    step(1); step(1);
    chk("order_n", 0, 64'(dq.size()), 64'd3);
    if (dq.size() == 3) begin
      chk("order0", 0, dq[0], 64'hA);
      chk("order1", 0, dq[1], 64'hB);
      chk("order2", 0, dq[2], 64'hC);
    end

    // Flush while FULL with input offered, then flush of an empty stage
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h21;
    step(1);
    in_data = 64'h22;
    step(1);
    base = 64'(fcnt[0]);
    flush = 1'b1; in_data = 64'h23;
    step(1);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 0, 64'(vld[0]), 64'd0);
    chk("flush_data",  0, dat[0], CLR);
    chk("flush_rdy",   0, 64'(rdy[0]), 64'd1);
    chk("flush_cnt1",  0, 64'(fcnt[0]), base + 64'd1);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("flush_empty", 0, 64'(fcnt[0]), base + 64'd1);

    // Single-entry stage: combinational in_ready, replace, flush with in_fire
    in_valid = 1'b1; in_data = 64'h5;
    step(1);
    in_data = 64'h99;
    chk("single_block", 1, 64'(rdy[1]), 64'd0);
    step(1);
    chk("single_hold", 1, dat[1], 64'h5);
    out_ready = 1'b1; in_data = 64'h6;
    step(1);
    chk("single_next", 1, dat[1], 64'h6);
    flush = 1'b1; in_data = 64'h7;
    step(1);
    flush = 1'b0; in_valid = 1'b0;
    chk("single_flush_v", 1, 64'(vld[1]), 64'd0);
    chk("single_flush_d", 1, dat[1], CLR);

    // 2-bit stall counter saturation
    reset = 1'b1;
    step(1);
    reset = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h31;
    step(1);
    in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      chk("sat_stall", 2, 64'(scnt[2]), (k < 3) ? 64'(k) : 64'd3);
    end

    // Reset and flush together: reset wins, counters cleared
    reset = 1'b1; flush = 1'b1;
    step(1);
    reset = 1'b0; flush = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("rstflush_cnt", i, 64'(fcnt[i]), 64'd0);
      chk("rstflush_v",   i, 64'(vld[i]), 64'd0);
    end

    // Randomised traffic against the model
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      in_data   = {$urandom, $urandom};
      step(1);
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
